// File: rtl/hopfield_activity_monitor.sv
// Spike activity monitor: per-cycle popcount, saturating windowed total with threshold flag,
// and pattern-stability detector. Optional peak tracking under HOPFIELD_PEAK_TRACK_EN.
module hopfield_activity_monitor #(
  parameter int unsigned N_NEURONS     = 7,
  parameter int unsigned WINDOW        = 16,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ACC_W         = 8,
  localparam int unsigned POP_W        = $clog2(N_NEURONS + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [N_NEURONS-1:0] spikes,
  input  logic [ACC_W-1:0]     thresh,
  output logic [POP_W-1:0]     inst_count,
  output logic [ACC_W-1:0]     win_count,
  output logic                 win_valid,
  output logic                 above_thresh,
  output logic                 converged,
  output logic                 running
`ifdef HOPFIELD_PEAK_TRACK_EN
  ,
  output logic [ACC_W-1:0]     peak_count
`endif
);

  localparam int unsigned PH_W = $clog2(WINDOW);
  localparam int unsigned ST_W = $clog2(STABLE_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ACC_W-1:0]     r_acc;
  logic [PH_W-1:0]      r_phase;
  logic [N_NEURONS-1:0] r_prev;
  logic [ST_W-1:0]      r_stable;
  logic [POP_W-1:0]     r_inst;
  logic [ACC_W-1:0]     r_win;
  logic                 r_valid;
  logic                 r_above;
  logic                 r_conv;

  logic [POP_W-1:0]     w_pop;
  logic [ACC_W-1:0]     w_acc_base;
  logic [PH_W-1:0]      w_phase_base;
  logic [ACC_W:0]       w_sum;
  logic [ACC_W-1:0]     w_sat;
  logic                 w_win_end;
  logic [ST_W-1:0]      w_stable_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear)       w_state_nxt = IDLE;
    else if (enable) w_state_nxt = RUN;
    else             w_state_nxt = IDLE;
  end

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < N_NEURONS; i++) w_pop = w_pop + POP_W'(spikes[i]);
  end

  // Entering RUN starts a fresh window, so stale acc/phase from a dropped window are masked.
  always_comb begin
    w_acc_base   = (r_state == RUN) ? r_acc : '0;
    w_phase_base = (r_state == RUN) ? r_phase : '0;
    w_sum        = {1'b0, w_acc_base} + (ACC_W + 1)'(w_pop);
    w_sat        = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
    w_win_end    = (w_phase_base == PH_W'(WINDOW - 1));
    if (spikes != r_prev)                         w_stable_nxt = '0;
    else if (r_stable == ST_W'(STABLE_CYCLES))    w_stable_nxt = r_stable;
    else                                          w_stable_nxt = r_stable + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_phase  <= '0;
      r_prev   <= '0;
      r_stable <= '0;
      r_inst   <= '0;
      r_win    <= '0;
      r_valid  <= 1'b0;
      r_above  <= 1'b0;
      r_conv   <= 1'b0;
    end else if (clear) begin
      r_acc    <= '0;
      r_phase  <= '0;
      r_prev   <= '0;
      r_stable <= '0;
      r_inst   <= '0;
      r_win    <= '0;
      r_valid  <= 1'b0;
      r_above  <= 1'b0;
      r_conv   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (enable) begin
        r_inst <= w_pop;
        if (w_win_end) begin
          r_win   <= w_sat;
          r_above <= (w_sat >= thresh);
          r_valid <= 1'b1;
          r_acc   <= '0;
          r_phase <= '0;
        end else begin
          r_acc   <= w_sat;
          r_phase <= w_phase_base + 1'b1;
        end
        r_prev   <= spikes;
        r_stable <= w_stable_nxt;
        r_conv   <= (w_stable_nxt == ST_W'(STABLE_CYCLES));
      end
    end
  end

`ifdef HOPFIELD_PEAK_TRACK_EN
  logic [ACC_W-1:0] r_peak;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                           r_peak <= '0;
    else if (clear)                                       r_peak <= '0;
    else if (enable && w_win_end && (w_sat > r_peak))     r_peak <= w_sat;
  end

  assign peak_count = r_peak;
`endif

  assign inst_count   = r_inst;
  assign win_count    = r_win;
  assign win_valid    = r_valid;
  assign above_thresh = r_above;
  assign converged    = r_conv;
  assign running      = (r_state == RUN);

endmodule

// File: tb/tb_hopfield_activity_monitor.sv
// Bench for hopfield_activity_monitor: window-level model checked every cycle on two instances
// (ACC_W=8 and ACC_W=6) plus directed literal expectations.
module tb_hopfield_activity_monitor;

  localparam int W  = 16;
  localparam int SC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       clear = 1'b0;
  logic [6:0] spikes = '0;
  logic [7:0] thresh = '0;
  logic [5:0] thresh6;

  logic [2:0] a_inst, b_inst;
  logic [7:0] a_win;
  logic [5:0] b_win;
  logic       a_valid, b_valid, a_above, b_above, a_conv, b_conv, a_run, b_run;
`ifdef HOPFIELD_PEAK_TRACK_EN
  logic [7:0] a_peak;
  logic [5:0] b_peak;
`endif

  int n_checks = 0;
  int n_errs   = 0;

  assign thresh6 = thresh[5:0];

  always #5 clk = ~clk;

  hopfield_activity_monitor #(.N_NEURONS(7), .WINDOW(W), .STABLE_CYCLES(SC), .ACC_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .spikes(spikes), .thresh(thresh),
    .inst_count(a_inst), .win_count(a_win), .win_valid(a_valid), .above_thresh(a_above),
    .converged(a_conv), .running(a_run)
`ifdef HOPFIELD_PEAK_TRACK_EN
    , .peak_count(a_peak)
`endif
  );

  hopfield_activity_monitor #(.N_NEURONS(7), .WINDOW(W), .STABLE_CYCLES(SC), .ACC_W(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .spikes(spikes), .thresh(thresh6),
    .inst_count(b_inst), .win_count(b_win), .win_valid(b_valid), .above_thresh(b_above),
    .converged(b_conv), .running(b_run)
`ifdef HOPFIELD_PEAK_TRACK_EN
    , .peak_count(b_peak)
`endif
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: window total is the plain sum of samples since window start, clipped to the max.
  bit         m_run;
  int         m_n, m_sum, m_stab;
  logic [6:0] m_prev;
  int e_inst, e_win8, e_win6, e_valid, e_above8, e_above6, e_conv, e_peak8, e_peak6;

  task automatic mreset();
    m_run = 0; m_n = 0; m_sum = 0; m_stab = 0; m_prev = '0;
    e_inst = 0; e_win8 = 0; e_win6 = 0; e_valid = 0; e_above8 = 0; e_above6 = 0;
    e_conv = 0; e_peak8 = 0; e_peak6 = 0;
  endtask

  task automatic mstep();
    int pop;
    e_valid = 0;
    if (clear) begin
      mreset();
    end else if (enable) begin
      if (!m_run) begin
        m_n = 0;
        m_sum = 0;
      end
      pop = $countones(spikes);
      e_inst = pop;
      m_sum += pop;
      m_n++;
      if (m_n == W) begin
        e_win8   = (m_sum > 255) ? 255 : m_sum;
        e_win6   = (m_sum > 63) ? 63 : m_sum;
        e_above8 = (e_win8 >= int'(thresh)) ? 1 : 0;
        e_above6 = (e_win6 >= int'(thresh6)) ? 1 : 0;
        if (e_win8 > e_peak8) e_peak8 = e_win8;
        if (e_win6 > e_peak6) e_peak6 = e_win6;
        e_valid = 1;
        m_n = 0;
        m_sum = 0;
      end
      if (spikes == m_prev) m_stab = (m_stab + 1 > SC) ? SC : m_stab + 1;
      else                  m_stab = 0;
      m_prev = spikes;
      e_conv = (m_stab == SC) ? 1 : 0;
      m_run = 1;
    end else begin
      m_run = 0;
    end
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk);
      if (!rst_n) mreset();
      else        mstep();
      @(negedge clk);
      if (!rst_n) mreset();
      chk("inst_count",   int'(a_inst),  e_inst);
      chk("win_count",    int'(a_win),   e_win8);
      chk("win_valid",    int'(a_valid), e_valid);
      chk("above_thresh", int'(a_above), e_above8);
      chk("converged",    int'(a_conv),  e_conv);
      chk("running",      int'(a_run),   m_run ? 1 : 0);
      chk("w6_win_count", int'(b_win),   e_win6);
      chk("w6_valid",     int'(b_valid), e_valid);
      chk("w6_above",     int'(b_above), e_above6);
      chk("w6_inst",      int'(b_inst),  e_inst);
`ifdef HOPFIELD_PEAK_TRACK_EN
      chk("peak_count",   int'(a_peak),  e_peak8);
      chk("w6_peak",      int'(b_peak),  e_peak6);
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with spikes all-ones and enable high
    spikes = 7'h7F; enable = 1'b1; thresh = 8'd48;
    repeat (3) @(negedge clk);
    chk("rst_running", int'(a_run), 0);
    chk("rst_inst", int'(a_inst), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_running", int'(a_run), 1);
    chk("post_rst_inst", int'(a_inst), 7);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;

    // Window of pop=3, thresh 48 then 49
    spikes = 7'b0000111;
    @(negedge clk);
    chk("t2_inst", int'(a_inst), 3);
    repeat (14) @(negedge clk);
    chk("t2_no_valid_e15", int'(a_valid), 0);
    @(negedge clk);
    chk("t2_valid", int'(a_valid), 1);
    chk("t2_win", int'(a_win), 48);
    chk("t3_above_48", int'(a_above), 1);
    thresh = 8'd49;
    repeat (16) @(negedge clk);
    chk("t3_valid2", int'(a_valid), 1);
    chk("t3_above_49", int'(a_above), 0);

    // All-ones window: 112 for ACC_W=8, saturates to 63 for ACC_W=6
    spikes = 7'h7F;
    repeat (16) @(negedge clk);
    chk("t4_win8", int'(a_win), 112);
    chk("t4_win6_sat", int'(b_win), 63);

    // Enable gap discards the partial window
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; spikes = 7'b0000011;
    repeat (5) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_idle", int'(a_run), 0);
    enable = 1'b1;
    repeat (15) @(negedge clk);
    chk("t5_no_valid_e15", int'(a_valid), 0);
    @(negedge clk);
    chk("t5_valid_e16", int'(a_valid), 1);
    chk("t5_win", int'(a_win), 32);

    // Convergence, then clear on a window-end edge
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; spikes = 7'b1010101;
    @(negedge clk);
    chk("t6_conv_e1", int'(a_conv), 0);
    repeat (3) @(negedge clk);
    chk("t6_conv_e4", int'(a_conv), 0);
    @(negedge clk);
    chk("t6_conv_e5", int'(a_conv), 1);
    spikes = 7'b1010100;
    @(negedge clk);
    chk("t6_conv_toggle", int'(a_conv), 0);
    repeat (9) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    chk("t6_clr_valid", int'(a_valid), 0);
    chk("t6_clr_win", int'(a_win), 0);
    chk("t6_clr_run", int'(a_run), 0);
    chk("t6_clr_inst", int'(a_inst), 0);
    clear = 1'b0;

    // Windows of 48 then 20: peak holds the larger
    spikes = 7'b0000111;
    repeat (16) @(negedge clk);
    chk("pk_win48", int'(a_win), 48);
    spikes = 7'b0000001;
    repeat (12) @(negedge clk);
    spikes = 7'b0000011;
    repeat (4) @(negedge clk);
    chk("pk_win20", int'(a_win), 20);
`ifdef HOPFIELD_PEAK_TRACK_EN
    chk("pk_peak48", int'(a_peak), 48);
`endif
    enable = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
